// File: rtl/alu_mul_seq_pkg.sv
// Shared types and helpers for the shift-add multiplier sequencer.
//   mul_state_t : sequencer FSM states (IDLE, RUN, DONE)
//   step_func   : selects the ALU function for one multiplier bit
// The ALU opcode macros normally come from the core's global defines. The
// guarded fallbacks below keep this slice self-contained.
`ifndef N_BIT
`define N_BIT 32
`endif
`ifndef ALU_FUNC_SIZE
`define ALU_FUNC_SIZE 4
`endif
`ifndef ALU_OP1
`define ALU_OP1 4'h0
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'h2
`endif

package alu_mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // When the current multiplier bit is set, the step adds the multiplicand
  // into the hi accumulator. Otherwise it passes operand A (hi) through
  // unchanged with a zero carry.
  function automatic logic [`ALU_FUNC_SIZE-1:0] step_func(input logic mult_bit);
    return mult_bit ? `ALU_ADD : `ALU_OP1;
  endfunction

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned shift-add multiplier controller (MULTU).
// The block borrows the shared ALU for one ADD or OP1 pass per multiplier bit.
// It builds the 2*WIDTH product in the hi/lo registers. Latency is fixed:
// after start is accepted, RUN lasts WIDTH cycles and is followed by a
// single-cycle DONE.
// Ports:
//   clock, reset       posedge clock; synchronous active-high reset
//   start              request; accepted only in IDLE or DONE
//   op_a, op_b         multiplicand and multiplier, sampled on accept
//   busy               high exactly while in RUN
//   done               one-cycle pulse; the product is valid
//   prod_hi, prod_lo   product halves; held until the next accept
//   ovf                prod_hi != 0; registered on entry to DONE
//   alu_own            top level routes alu_a/alu_b/alu_func to the ALU
//   alu_a, alu_b       running hi accumulator and latched multiplicand
//   alu_func           `ALU_ADD or `ALU_OP1
//   alu_out            ALU result; bit WIDTH is the carry
`ifndef N_BIT
`define N_BIT 32
`endif
`ifndef ALU_FUNC_SIZE
`define ALU_FUNC_SIZE 4
`endif
`ifndef ALU_OP1
`define ALU_OP1 4'h0
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'h2
`endif

module alu_mul_sequencer
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = `N_BIT,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          op_a,
  input  logic [WIDTH-1:0]          op_b,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          prod_hi,
  output logic [WIDTH-1:0]          prod_lo,
  output logic                      ovf,
  output logic                      alu_own,
  output logic [WIDTH-1:0]          alu_a,
  output logic [WIDTH-1:0]          alu_b,
  output logic [`ALU_FUNC_SIZE-1:0] alu_func,
  input  logic [WIDTH:0]            alu_out
);

  mul_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             ovf_q;
  logic             accept;
  logic             last_step;

  // Next state, accept/step decode and ALU request
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    alu_own   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_func  = `ALU_OP1;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        alu_own   = 1'b1;
        alu_a     = hi;
        alu_b     = mcand;
        // lo[0] always holds the multiplier bit for this step, because lo
        // shifts right once per step.
        alu_func  = step_func(lo[0]);
        last_step = (cnt == CNT_W'(WIDTH - 1));
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        // Back-to-back accept: the done pulse is still presented this cycle.
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and hi/lo shift register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand <= op_a;
        hi    <= '0;
        lo    <= op_b;
        cnt   <= '0;
        ovf_q <= 1'b0;
      end else if (state == RUN) begin
        // (2*WIDTH+1)-bit right shift. The ALU carry becomes the new top bit
        // of hi, and the consumed multiplier bit drops off the bottom of lo.
        {hi, lo} <= {alu_out, lo[WIDTH-1:1]};
        cnt      <= cnt + CNT_W'(1);
        if (last_step) ovf_q <= |alu_out[WIDTH:1];
      end
    end
  end

  assign prod_hi = hi;
  assign prod_lo = lo;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer (WIDTH=32).
// It includes a behavioural ALU and the top-level alu_own mux.
// The reference model is plain 64-bit multiplication. The expected per-step
// ALU function is taken directly from the multiplier bits.
`ifndef N_BIT
`define N_BIT 32
`endif
`ifndef ALU_FUNC_SIZE
`define ALU_FUNC_SIZE 4
`endif
`ifndef ALU_OP1
`define ALU_OP1 4'h0
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'h2
`endif

module tb_alu_mul_sequencer;
  localparam int W = 32;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      start;
  logic [W-1:0]              op_a, op_b;
  logic                      busy, done, ovf, alu_own;
  logic [W-1:0]              prod_hi, prod_lo, alu_a, alu_b;
  logic [`ALU_FUNC_SIZE-1:0] alu_func;
  logic [W:0]                alu_out;

  // Shared ALU behind the top-level mux. The single-cycle datapath side is
  // idle (zeros) in this bench.
  logic [W-1:0]              mux_a, mux_b;
  logic [`ALU_FUNC_SIZE-1:0] mux_func;

  always_comb begin
    mux_a    = alu_own ? alu_a : '0;
    mux_b    = alu_own ? alu_b : '0;
    mux_func = alu_own ? alu_func : `ALU_OP1;
    if (mux_func == `ALU_ADD) alu_out = {1'b0, mux_a} + {1'b0, mux_b};
    else                      alu_out = {1'b0, mux_a};
  end

  alu_mul_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo), .ovf(ovf),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
    .alu_func(alu_func), .alu_out(alu_out)
  );

  always #5 clock = ~clock;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Outputs while no operation is in flight; prod is the held product.
  task automatic idle_check(input string tag, input logic [63:0] prod);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_alu_if"}, {29'd0, alu_own, alu_func, alu_a != '0, alu_b != '0},
        {29'd0, 1'b0, `ALU_OP1, 1'b0, 1'b0});
    chk({tag, "_prod"}, {prod_hi, prod_lo}, prod);
    chk({tag, "_ovf"}, 64'(ovf), 64'(prod[63:32] != '0));
  endtask

  // Issue start in the current cycle, then follow the op to its done cycle.
  // If repulse >= 0, start is re-pulsed with 7*7 in RUN cycle T+1+repulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int repulse);
    logic [W-1:0] fseq;
    logic         bad;
    logic [63:0]  exp_p;
    exp_p = 64'(a) * 64'(b);
    start = 1'b1; op_a = a; op_b = b;
    tick;
    start = 1'b0;
    fseq  = '0;
    bad   = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!busy || done || !alu_own || alu_b != a) bad = 1'b1;
      fseq[i] = (alu_func == `ALU_ADD);
      if (i == repulse) begin
        start = 1'b1; op_a = 32'd7; op_b = 32'd7;
      end
      tick;
      start = 1'b0;
    end
    chk("run_window", 64'(bad), 64'd0);
    chk("func_seq", 64'(fseq), 64'(b));
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("product", {prod_hi, prod_lo}, exp_p);
    chk("ovf", 64'(ovf), 64'(exp_p[63:32] != '0));
  endtask

  initial begin
    logic        saw_done;
    logic [31:0] ra, rb;
    start = 1'b0; op_a = '0; op_b = '0;
    reset = 1'b1;
    tick;
    tick;
    idle_check("reset", 64'd0);
    reset = 1'b0;
    tick;
    idle_check("post_reset", 64'd0);

    run_op(32'd3, 32'd5, -1);
    tick;
    idle_check("hold_15", 64'd15);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    tick;
    idle_check("hold_max", 64'hFFFF_FFFE_0000_0001);

    run_op(32'd0, 32'h8000_0001, -1);
    tick;
    run_op(32'h1234, 32'd0, -1);
    tick;
    idle_check("hold_zero", 64'd0);

    // A re-pulse mid-run is ignored; then start is held in the DONE cycle.
    run_op(32'd3, 32'd5, 4);
    run_op(32'd7, 32'd7, -1);
    tick;
    idle_check("hold_49", 64'd49);

    // Reset while an op is running
    start = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    tick;
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    idle_check("abort", 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick;
    end
    chk("abort_quiet", 64'(saw_done), 64'd0);
    run_op(32'd100, 32'd200, -1);
    tick;
    idle_check("after_abort", 64'd20000);

    // Random pairs, mixing back-to-back and gapped issue
    for (int k = 0; k < 1000; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k % 4 == 0) rb = $urandom_range(0, 255);
      if (k % 7 == 0) ra = $urandom_range(0, 15);
      run_op(ra, rb, -1);
      if ($urandom_range(0, 1) == 1) begin
        tick;
        chk("single_pulse", 64'(done), 64'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
